constraint_sampler: RTL and testbench

Rejection-sampling front end for the split constraint checkers. It draws pseudo-random candidate values for a two-operand constraint from an internal LFSR and presents them to the combinational checker. It samples the checker's single-bit verdict and retries until the verdict is true or a try budget runs out. Accepted candidates go out on a valid/ready stream to the downstream solution collector.

---
 rtl/sampler_pkg.sv | 20 ++
 rtl/constraint_sampler_if.sv | 29 ++
 rtl/lfsr32_galois.sv | 37 +++
 rtl/constraint_sampler.sv | 135 +++++++++++++
 tb/tb_constraint_sampler.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sampler_pkg.sv
// Shared types and constants for the rejection samplers: FSM states, LFSR
// polynomial and the try-counter width.
package sampler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam int          TRY_W     = 16;

    // One right-shift Galois step; feedback taps are XORed in when bit 0 falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/constraint_sampler_if.sv
// Request / checker / sample-stream bundle between a constraint sampler and its
// surroundings (requester, combinational checker, solution collector).
interface constraint_sampler_if #(
    parameter int W_A = 13,
    parameter int W_B = 8
);
    logic           req_valid;
    logic           req_ready;
    logic [W_A-1:0] cand_a;
    logic [W_B-1:0] cand_b;
    logic           chk_x;
    logic           smp_valid;
    logic           smp_ready;
    logic [W_A-1:0] smp_a;
    logic [W_B-1:0] smp_b;
    logic [15:0]    smp_tries;
    logic           fail;
    logic           busy;

    modport master (
        input  req_valid, chk_x, smp_ready,
        output req_ready, cand_a, cand_b, smp_valid, smp_a, smp_b, smp_tries, fail, busy
    );

    modport slave (
        output req_valid, chk_x, smp_ready,
        input  req_ready, cand_a, cand_b, smp_valid, smp_a, smp_b, smp_tries, fail, busy
    );
endinterface

// File: rtl/lfsr32_galois.sv
// 32-bit right-shifting Galois LFSR with enable; reset loads the supplied seed.
module lfsr32_galois
    import sampler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] seed,
    output logic [31:0] q
);

    logic [31:0] q_reg;
    logic [31:0] q_next;

    // Bit gi takes its upper neighbour, XORed with the outgoing bit where the polynomial has a tap.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_tap
            if (gi == 31) begin : g_top
                assign q_next[gi] = LFSR_POLY[gi] & q_reg[0];
            end else begin : g_mid
                assign q_next[gi] = q_reg[gi+1] ^ (LFSR_POLY[gi] & q_reg[0]);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= seed;
        end else if (en) begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/constraint_sampler.sv
// Rejection sampler: draws LFSR candidates, retries until the external checker
// accepts or the try budget runs out, and streams accepted samples downstream.
module constraint_sampler
    import sampler_pkg::*;
#(
    parameter int          W_A       = 13,
    parameter int          W_B       = 8,
    parameter int          MAX_TRIES = 1024,
    parameter logic [31:0] SEED      = 32'hACE1_2468
)(
    input logic                  clk,
    input logic                  rst,
    constraint_sampler_if.master bus
);

    localparam int               CAND_W   = W_A + W_B;
    localparam logic [31:0]      SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [TRY_W-1:0] MAX_T    = TRY_W'(MAX_TRIES);

    state_t             state_reg, state_next;
    logic [W_A-1:0]     cand_a_reg, cand_a_next;
    logic [W_B-1:0]     cand_b_reg, cand_b_next;
    logic [W_A-1:0]     smp_a_reg, smp_a_next;
    logic [W_B-1:0]     smp_b_reg, smp_b_next;
    logic [TRY_W-1:0]   tries_reg, tries_next;
    logic [TRY_W-1:0]   smp_tries_reg, smp_tries_next;
    logic               fail_reg, fail_next;

    logic [31:0]        lfsr_q;
    logic [CAND_W-1:0]  cand_bits;
    logic               lfsr_en;
    logic               req_ready_c, smp_valid_c, busy_c;

    assign lfsr_en = (state_reg == GEN);

    lfsr32_galois u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (lfsr_en),
        .seed (SEED_EFF),
        .q    (lfsr_q)
    );

    // Candidate is sliced from the value the LFSR takes on this GEN edge.
    assign cand_bits = CAND_W'(lfsr_step(lfsr_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cand_a_reg    <= '0;
            cand_b_reg    <= '0;
            smp_a_reg     <= '0;
            smp_b_reg     <= '0;
            tries_reg     <= '0;
            smp_tries_reg <= '0;
            fail_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cand_a_reg    <= cand_a_next;
            cand_b_reg    <= cand_b_next;
            smp_a_reg     <= smp_a_next;
            smp_b_reg     <= smp_b_next;
            tries_reg     <= tries_next;
            smp_tries_reg <= smp_tries_next;
            fail_reg      <= fail_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cand_a_next    = cand_a_reg;
        cand_b_next    = cand_b_reg;
        smp_a_next     = smp_a_reg;
        smp_b_next     = smp_b_reg;
        tries_next     = tries_reg;
        smp_tries_next = smp_tries_reg;
        fail_next      = 1'b0;
        req_ready_c    = 1'b0;
        smp_valid_c    = 1'b0;
        busy_c         = 1'b1;

        case (state_reg)
            IDLE: begin
                req_ready_c = 1'b1;
                busy_c      = 1'b0;
                if (bus.req_valid) begin
                    tries_next = '0;
                    state_next = GEN;
                end
            end
            GEN: begin
                cand_a_next = cand_bits[W_A-1:0];
                cand_b_next = cand_bits[CAND_W-1:W_A];
                // Saturate so a huge budget never wraps back to zero.
                if (tries_reg != {TRY_W{1'b1}}) begin
                    tries_next = tries_reg + 1'b1;
                end
                state_next = CHECK;
            end
            CHECK: begin
                if (bus.chk_x) begin
                    smp_a_next     = cand_a_reg;
                    smp_b_next     = cand_b_reg;
                    smp_tries_next = tries_reg;
                    state_next     = HOLD;
                end else if (tries_reg == MAX_T) begin
                    fail_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = GEN;
                end
            end
            HOLD: begin
                smp_valid_c = 1'b1;
                if (bus.smp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.smp_valid = smp_valid_c;
    assign bus.busy      = busy_c;
    assign bus.cand_a    = cand_a_reg;
    assign bus.cand_b    = cand_b_reg;
    assign bus.smp_a     = smp_a_reg;
    assign bus.smp_b     = smp_b_reg;
    assign bus.smp_tries = smp_tries_reg;
    assign bus.fail      = fail_reg;

endmodule

// File: tb/tb_constraint_sampler.sv
// Bench for constraint_sampler: three instances (default, tiny budget, zero seed)
// driven with directed and random requests against an arithmetic reference model.
module tb_constraint_sampler;

    localparam int          WA       = 13;
    localparam int          WB       = 8;
    localparam logic [31:0] DEF_SEED = 32'hACE1_2468;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    constraint_sampler_if #(.W_A(WA), .W_B(WB)) b0 ();
    constraint_sampler_if #(.W_A(WA), .W_B(WB)) b1 ();
    constraint_sampler_if #(.W_A(WA), .W_B(WB)) b2 ();

    constraint_sampler #(.W_A(WA), .W_B(WB)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    constraint_sampler #(.W_A(WA), .W_B(WB), .MAX_TRIES(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    constraint_sampler #(.W_A(WA), .W_B(WB), .MAX_TRIES(16), .SEED(32'h0)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    int checks = 0;
    int errors = 0;
    int chk_mode = 0;

    // Checker modes: 0 always true, 1 reference constraint, 2 sparse, other always false.
    function automatic logic xfun(input int mode, input logic [WA-1:0] a, input logic [WB-1:0] b);
        case (mode)
            0:       return 1'b1;
            1:       return (a == '0) || (b != '0);
            2:       return (a % 8) == 0;
            default: return 1'b0;
        endcase
    endfunction

    assign b0.chk_x = xfun(chk_mode, b0.cand_a, b0.cand_b);
    assign b1.chk_x = 1'b0;
    assign b2.chk_x = xfun(1, b2.cand_a, b2.cand_b);

    function automatic logic [31:0] step(input logic [31:0] s);
        return (s >> 1) ^ ((s % 2 == 1) ? 32'h8020_0003 : 32'h0);
    endfunction

    // Reference: walk the sequence until the checker accepts or the budget is spent.
    task automatic model_req(inout logic [31:0] s, input int mode, input int maxt,
                             output int tries, output logic ok,
                             output logic [WA-1:0] a, output logic [WB-1:0] b);
        ok = 1'b0; tries = 0; a = '0; b = '0;
        for (int t = 1; t <= maxt; t++) begin
            s = step(s);
            a = WA'(s);
            b = WB'(s >> WA);
            tries = t;
            if (xfun(mode, a, b)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request on dut0 and wait (bounded) for a sample or a fail pulse.
    task automatic do_req0(input int mode, output int lat, output logic got_v, output logic got_f);
        chk_mode = mode;
        b0.req_valid = 1'b1;
        @(posedge clk); #1;
        b0.req_valid = 1'b0;
        lat = 0;
        while (!b0.smp_valid && !b0.fail && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        got_v = b0.smp_valid;
        got_f = b0.fail;
    endtask

    task automatic take0();
        b0.smp_ready = 1'b1;
        @(posedge clk); #1;
        b0.smp_ready = 1'b0;
    endtask

    logic seen_v1 = 1'b0;
    always @(posedge clk) if (b1.smp_valid) seen_v1 <= 1'b1;

    logic [31:0]   m0, m2;
    int            et, lat;
    logic          eok, gv, gf;
    logic [WA-1:0] ea;
    logic [WB-1:0] eb;

    initial begin
        rst = 1'b1;
        b0.req_valid = 1'b0; b0.smp_ready = 1'b0;
        b1.req_valid = 1'b0; b1.smp_ready = 1'b1;
        b2.req_valid = 1'b0; b2.smp_ready = 1'b1;
        m0 = DEF_SEED;
        m2 = 32'h1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", b0.req_ready, 1);
        check("rst_smp_valid", b0.smp_valid, 0);
        check("rst_fail", b0.fail, 0);
        check("rst_busy", b0.busy, 0);
        check("rst_cand_a", b0.cand_a, 0);
        check("rst_cand_b", b0.cand_b, 0);
        check("rst_smp_tries", b0.smp_tries, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Always-true checker: first candidate accepted after two cycles.
        model_req(m0, 0, 1024, et, eok, ea, eb);
        do_req0(0, lat, gv, gf);
        $display("req first: lat=%0d a=%0h b=%0h tries=%0d", lat, b0.smp_a, b0.smp_b, b0.smp_tries);
        check("first_valid", gv, 1);
        check("first_lat", lat, 2);
        check("first_tries", b0.smp_tries, 1);
        check("first_a", b0.smp_a, ea);
        check("first_b", b0.smp_b, eb);
        check("first_busy", b0.busy, 1);
        take0();
        check("first_drop", b0.smp_valid, 0);
        check("first_idle", b0.req_ready, 1);

        // Budget of 4 with a never-true checker.
        b1.req_valid = 1'b1;
        @(posedge clk); #1;
        b1.req_valid = 1'b0;
        lat = 0;
        while (!b1.fail && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("req budget: fail after %0d cycles", lat);
        check("budget_fail_lat", lat, 8);
        @(posedge clk); #1;
        check("budget_fail_pulse", b1.fail, 0);
        check("budget_idle", b1.req_ready, 1);
        check("budget_busy", b1.busy, 0);
        check("budget_no_valid", seen_v1, 0);

        // Random mix of checkers against the model.
        for (int i = 0; i < 200; i++) begin
            int mode;
            mode = (i < 150) ? 1 : 2;
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            model_req(m0, mode, 1024, et, eok, ea, eb);
            do_req0(mode, lat, gv, gf);
            $display("req %0d mode=%0d: lat=%0d v=%0b f=%0b a=%0h b=%0h tries=%0d",
                     i, mode, lat, gv, gf, b0.smp_a, b0.smp_b, b0.smp_tries);
            check("rnd_valid", gv, eok);
            check("rnd_fail", gf, !eok);
            check("rnd_lat", lat, 2 * et);
            if (eok) begin
                check("rnd_a", b0.smp_a, ea);
                check("rnd_b", b0.smp_b, eb);
                check("rnd_tries", b0.smp_tries, et);
                check("rnd_sat", xfun(mode, b0.smp_a, b0.smp_b), 1);
                take0();
            end else begin
                @(posedge clk); #1;
            end
        end

        // Downstream stall: outputs frozen and new requests ignored.
        model_req(m0, 0, 1024, et, eok, ea, eb);
        do_req0(0, lat, gv, gf);
        check("stall_valid", gv, 1);
        for (int c = 0; c < 10; c++) begin
            b0.req_valid = 1'b1;
            @(posedge clk); #1;
            check("stall_hold", b0.smp_valid, 1);
            check("stall_a", b0.smp_a, ea);
            check("stall_b", b0.smp_b, eb);
            check("stall_tries", b0.smp_tries, 1);
            check("stall_req_ready", b0.req_ready, 0);
        end
        b0.req_valid = 1'b0;
        take0();
        $display("req stall: transferred a=%0h b=%0h", ea, eb);
        check("stall_xfer", b0.smp_valid, 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_once", b0.smp_valid, 0);
            check("stall_idle", b0.busy, 0);
        end

        // Reset in CHECK of the third try.
        chk_mode = 3;
        b0.req_valid = 1'b1;
        @(posedge clk); #1;
        b0.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst3_busy_before", b0.busy, 1);
        @(negedge clk) rst = 1'b1;
        #1;
        $display("req reset: async reset during try 3");
        check("rst3_req_ready", b0.req_ready, 1);
        check("rst3_busy", b0.busy, 0);
        check("rst3_smp_valid", b0.smp_valid, 0);
        check("rst3_fail", b0.fail, 0);
        check("rst3_cand_a", b0.cand_a, 0);
        check("rst3_cand_b", b0.cand_b, 0);
        check("rst3_smp_a", b0.smp_a, 0);
        check("rst3_smp_tries", b0.smp_tries, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        m0 = DEF_SEED;
        m2 = 32'h1;
        model_req(m0, 0, 1024, et, eok, ea, eb);
        do_req0(0, lat, gv, gf);
        $display("req after reset: a=%0h b=%0h", b0.smp_a, b0.smp_b);
        check("rst3_again_a", b0.smp_a, ea);
        check("rst3_again_b", b0.smp_b, eb);
        check("rst3_again_tries", b0.smp_tries, 1);
        take0();

        // Zero seed: sequence starts from 1 and keeps running.
        for (int i = 0; i < 100; i++) begin
            model_req(m2, 1, 16, et, eok, ea, eb);
            b2.req_valid = 1'b1;
            @(posedge clk); #1;
            b2.req_valid = 1'b0;
            lat = 0;
            while (!b2.smp_valid && !b2.fail && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            $display("req seed0 %0d: lat=%0d v=%0b f=%0b a=%0h b=%0h tries=%0d",
                     i, lat, b2.smp_valid, b2.fail, b2.smp_a, b2.smp_b, b2.smp_tries);
            check("s0_valid", b2.smp_valid, eok);
            check("s0_lat", lat, 2 * et);
            if (eok) begin
                check("s0_a", b2.smp_a, ea);
                check("s0_b", b2.smp_b, eb);
                check("s0_tries", b2.smp_tries, et);
            end
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
